// File: rtl/uart_sender.sv
// UART transmitter: serialises one byte LSB first with a start bit and 1 or 2 stop bits.
// Every output is driven directly from a flop. Busy and done are reported back to the peripheral.
module uart_sender #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_d;
  logic [BW-1:0] baud_cnt, baud_d;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    shift_reg, shift_d;
  logic          stop_cnt, stop_d;
  logic          tx_d, busy_d, done_d;
  logic          baud_end, last_stop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      stop_cnt  <= 1'b0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_d;
      baud_cnt  <= baud_d;
      bit_idx   <= bit_d;
      shift_reg <= shift_d;
      stop_cnt  <= stop_d;
      tx        <= tx_d;
      tx_busy   <= busy_d;
      tx_done   <= done_d;
    end
  end

  always_comb begin
    baud_end  = (baud_cnt == BAUD_LAST);
    last_stop = (STOP_BITS == 1) || stop_cnt;

    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_idx;
    shift_d = shift_reg;
    stop_d  = stop_cnt;
    tx_d    = tx;
    busy_d  = tx_busy;
    done_d  = 1'b0;

    unique case (state)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          shift_d = tx_data;
          baud_d  = '0;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_reg[0];
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
            stop_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_idx + 3'd1;
            tx_d  = shift_reg[bit_idx + 3'd1];
          end
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_end) begin
          baud_d = '0;
          if (last_stop) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          baud_d = baud_cnt + 1'b1;
          // Registered done must rise one cycle early to land on the final stop cycle.
          if (last_stop && baud_cnt == BAUD_PRE) done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_sender.sv
// Directed bench for uart_sender at 4 clocks per bit, with one 1-stop-bit and one 2-stop-bit instance.
module tb_uart_sender;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_a = '0, data_b = '0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       tx_a, busy_a, done_a, tx_b, busy_b, done_b;

  always #5 clk = ~clk;

  uart_sender #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .tx_data(data_a), .tx_start(start_a),
    .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a)
  );

  uart_sender #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .tx_data(data_b), .tx_start(start_b),
    .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b)
  );

  int asserts = 0;
  int failures = 0;
  logic [127:0] tx_log, busy_log, done_log;
  int first_done, done_cnt;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic s, input logic [7:0] d);
    if (sel) begin start_b = s; data_b = d; end
    else begin start_a = s; data_a = d; end
  endtask

  // One-cycle request pulse; returns in the first cycle after the accept edge.
  task automatic start_frame(input bit sel, input logic [7:0] d);
    drive(sel, 1'b1, d);
    tick;
    drive(sel, 1'b0, d);
  endtask

  // Logs n cycles (k=1..n); optionally raises tx_start at poke_from and drops it at poke_to.
  task automatic capture(input bit sel, input int n, input int poke_from, input int poke_to,
                         input logic [7:0] poke_data);
    tx_log = '0; busy_log = '0; done_log = '0;
    first_done = 0; done_cnt = 0;
    for (int k = 1; k <= n; k++) begin
      if (k == poke_from) drive(sel, 1'b1, poke_data);
      if (k == poke_to) drive(sel, 1'b0, poke_data);
      tx_log[k-1]   = sel ? tx_b : tx_a;
      busy_log[k-1] = sel ? busy_b : busy_a;
      done_log[k-1] = sel ? done_b : done_a;
      if (done_log[k-1]) begin
        done_cnt++;
        if (first_done == 0) first_done = k;
      end
      tick;
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int pos);
    int b;
    if (pos < 0) return 1'b1;
    b = pos / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  function automatic logic [127:0] exp_tx(input logic [7:0] d, input int offset);
    logic [127:0] v;
    for (int i = 0; i < 128; i++) v[i] = exp_bit(d, i - offset);
    return v;
  endfunction

  function automatic logic [127:0] mask(input int n);
    return (128'(1) << n) - 128'(1);
  endfunction

  // Receiver model: samples each data bit in the middle of its bit period.
  function automatic logic [7:0] decode(input logic [127:0] log, input int offset);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = log[offset + (i + 1) * CPB + CPB / 2];
    return b;
  endfunction

  task automatic test_reset;
    tick; tick; tick;
    asserts++; if (tx_a !== 1'b1) begin failures++; $display("FAIL reset_tx got %b want 1", tx_a); end
    asserts++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy_a); end
    asserts++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", done_a); end
    asserts++; if (tx_b !== 1'b1) begin failures++; $display("FAIL reset_tx_b got %b want 1", tx_b); end
    reset = 1'b1;
    tick; tick;
  endtask

  task automatic test_frame_55;
    logic [127:0] e;
    start_frame(1'b0, 8'h55);
    capture(1'b0, 41, 0, 0, 8'h00);
    e = exp_tx(8'h55, 0) & mask(41);
    asserts++; if ((tx_log & mask(41)) !== e) begin failures++; $display("FAIL f55_tx got %h want %h", tx_log & mask(41), e); end
    asserts++; if (first_done !== 40) begin failures++; $display("FAIL f55_done_at got %0d want 40", first_done); end
    asserts++; if (done_cnt !== 1) begin failures++; $display("FAIL f55_done_cnt got %0d want 1", done_cnt); end
    asserts++; if ((busy_log & mask(41)) !== mask(40)) begin failures++; $display("FAIL f55_busy got %h want %h", busy_log & mask(41), mask(40)); end
  endtask

  task automatic test_frame_a3;
    logic [127:0] e;
    start_frame(1'b0, 8'hA3);
    capture(1'b0, 41, 0, 0, 8'h00);
    e = exp_tx(8'hA3, 0) & mask(41);
    asserts++; if ((tx_log & mask(41)) !== e) begin failures++; $display("FAIL fa3_tx got %h want %h", tx_log & mask(41), e); end
    asserts++; if (decode(tx_log, 0) !== 8'hA3) begin failures++; $display("FAIL fa3_decode got %h want a3", decode(tx_log, 0)); end
  endtask

  task automatic test_busy_ignore;
    logic [127:0] e;
    start_frame(1'b0, 8'h3C);
    capture(1'b0, 45, 10, 30, 8'hFF);
    e = exp_tx(8'h3C, 0) & mask(45);
    asserts++; if ((tx_log & mask(45)) !== e) begin failures++; $display("FAIL ign_tx got %h want %h", tx_log & mask(45), e); end
    asserts++; if (decode(tx_log, 0) !== 8'h3C) begin failures++; $display("FAIL ign_decode got %h want 3c", decode(tx_log, 0)); end
    asserts++; if (done_cnt !== 1) begin failures++; $display("FAIL ign_done_cnt got %0d want 1", done_cnt); end
    asserts++; if ((busy_log & mask(45)) !== mask(40)) begin failures++; $display("FAIL ign_busy got %h want %h", busy_log & mask(45), mask(40)); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] e, eb, ed;
    start_a = 1'b1; data_a = 8'h00;
    tick;
    capture(1'b0, 82, 2, 42, 8'hFF);
    e  = exp_tx(8'h00, 0) & exp_tx(8'hFF, 41) & mask(82);
    eb = mask(81) & ~(128'(1) << 40);
    ed = (128'(1) << 39) | (128'(1) << 80);
    asserts++; if ((tx_log & mask(82)) !== e) begin failures++; $display("FAIL b2b_tx got %h want %h", tx_log & mask(82), e); end
    asserts++; if ((done_log & mask(82)) !== ed) begin failures++; $display("FAIL b2b_done got %h want %h", done_log & mask(82), ed); end
    asserts++; if ((busy_log & mask(82)) !== eb) begin failures++; $display("FAIL b2b_busy got %h want %h", busy_log & mask(82), eb); end
    asserts++; if (decode(tx_log, 41) !== 8'hFF) begin failures++; $display("FAIL b2b_decode2 got %h want ff", decode(tx_log, 41)); end
  endtask

  task automatic test_reset_mid_frame;
    logic [127:0] e;
    start_frame(1'b0, 8'hC3);
    for (int i = 0; i < 17; i++) tick;
    asserts++; if (tx_a !== 1'b0) begin failures++; $display("FAIL mid_bit3 got %b want 0", tx_a); end
    #2 reset = 1'b0;
    #1;
    asserts++; if (tx_a !== 1'b1) begin failures++; $display("FAIL mid_rst_tx got %b want 1", tx_a); end
    asserts++; if (busy_a !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got %b want 0", busy_a); end
    asserts++; if (done_a !== 1'b0) begin failures++; $display("FAIL mid_rst_done got %b want 0", done_a); end
    tick; tick;
    reset = 1'b1;
    capture(1'b0, 45, 0, 0, 8'h00);
    asserts++; if (done_cnt !== 0) begin failures++; $display("FAIL mid_no_done got %0d want 0", done_cnt); end
    asserts++; if ((tx_log & mask(45)) !== mask(45)) begin failures++; $display("FAIL mid_idle_tx got %h want %h", tx_log & mask(45), mask(45)); end
    start_frame(1'b0, 8'h5A);
    capture(1'b0, 41, 0, 0, 8'h00);
    e = exp_tx(8'h5A, 0) & mask(41);
    asserts++; if ((tx_log & mask(41)) !== e) begin failures++; $display("FAIL f5a_tx got %h want %h", tx_log & mask(41), e); end
    asserts++; if (decode(tx_log, 0) !== 8'h5A) begin failures++; $display("FAIL f5a_decode got %h want 5a", decode(tx_log, 0)); end
    asserts++; if (first_done !== 40) begin failures++; $display("FAIL f5a_done_at got %0d want 40", first_done); end
  endtask

  task automatic test_two_stop;
    logic [127:0] e;
    start_frame(1'b1, 8'h81);
    capture(1'b1, 45, 0, 0, 8'h00);
    e = exp_tx(8'h81, 0) & mask(45);
    asserts++; if ((tx_log & mask(45)) !== e) begin failures++; $display("FAIL stop2_tx got %h want %h", tx_log & mask(45), e); end
    asserts++; if (tx_log[43:36] !== 8'hFF) begin failures++; $display("FAIL stop2_phase got %h want ff", tx_log[43:36]); end
    asserts++; if (first_done !== 44) begin failures++; $display("FAIL stop2_done_at got %0d want 44", first_done); end
    asserts++; if (done_cnt !== 1) begin failures++; $display("FAIL stop2_done_cnt got %0d want 1", done_cnt); end
    asserts++; if ((busy_log & mask(45)) !== mask(44)) begin failures++; $display("FAIL stop2_busy got %h want %h", busy_log & mask(45), mask(44)); end
  endtask

  initial begin
    test_reset;
    test_frame_55;
    test_frame_a3;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid_frame;
    test_two_stop;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
